// File: rtl/shacc_ctrl.sv
// Shift-accumulator controller: delays AGU beat flags by PIPE_LAT cycles and
// decodes them into load/acc/shift controls, output-valid beats, write address and done.
module shacc_ctrl #(
  parameter int BPREC    = 6,
  parameter int NJUMPS   = 5,
  parameter int BOBANKA  = 15,
  parameter int BOCNT    = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic               imsb,
  input  logic               wmsb,
  input  logic               sh,
  input  logic [NJUMPS-1:0]  wagu_on_j,
  input  logic [NJUMPS-1:0]  acc_out_sel,
  input  logic [BOBANKA-1:0] obaseaddr,
  input  logic [BOCNT-1:0]   ocount,
  output logic               shacc_load,
  output logic               shacc_acc,
  output logic               shacc_sh,
  output logic               shacc_imsb,
  output logic               shacc_wmsb,
  output logic               out_valid,
  output logic [BOBANKA-1:0] out_addr,
  output logic               done
);

  if (PIPE_LAT < 1 || PIPE_LAT > 8 || BPREC < 1) begin : g_param_check
    $error("shacc_ctrl: PIPE_LAT must be 1..8 and BPREC positive");
  end

  typedef struct packed {
    logic v;
    logic ld;
    logic eoa;
    logic sh;
    logic imsb;
    logic wmsb;
  } beat_t;

  beat_t            stage_q [PIPE_LAT];
  beat_t            stage_d [PIPE_LAT];
  beat_t            in_beat;
  beat_t            last;
  logic             eoa_in;
  logic             first_pending_q, first_pending_d;
  logic [BOCNT-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    eoa_in  = |(wagu_on_j & acc_out_sel);
    in_beat = '0;
    if (en) begin
      in_beat.v    = 1'b1;
      in_beat.ld   = first_pending_q;
      in_beat.eoa  = eoa_in;
      in_beat.sh   = sh;
      in_beat.imsb = imsb;
      in_beat.wmsb = wmsb;
    end

    stage_d[0] = in_beat;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end

    first_pending_d = first_pending_q;
    if (en) first_pending_d = eoa_in;

    // clr wins over en: the beat presented with clr never enters the pipe
    if (clr) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        stage_d[i] = '0;
      end
      first_pending_d = 1'b1;
    end
  end

  assign last       = stage_q[PIPE_LAT-1];
  assign shacc_load = last.v & last.ld;
  assign shacc_acc  = last.v & ~last.ld;
  assign shacc_sh   = last.v & last.sh & ~last.ld;
  assign shacc_imsb = last.v & last.imsb;
  assign shacc_wmsb = last.v & last.wmsb;
  assign out_valid  = last.v & last.eoa & ~done_q;
  assign out_addr   = obaseaddr + BOBANKA'(cnt_q);
  assign done       = done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (out_valid) begin
      cnt_d = cnt_q + BOCNT'(1);
      if (ocount != '0 && cnt_d == ocount) done_d = 1'b1;
    end
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        stage_q[i] <= '0;
      end
      first_pending_q <= 1'b1;
      cnt_q           <= '0;
      done_q          <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
      first_pending_q <= first_pending_d;
      cnt_q           <= cnt_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_shacc_ctrl.sv
// Self-checking bench for shacc_ctrl: directed scenarios plus random beats,
// compared each cycle against a time-stamped beat queue model.
module tb_shacc_ctrl;
  localparam int NJ  = 5;
  localparam int BA  = 15;
  localparam int BC  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n, clr, en, imsb, wmsb, sh;
  logic [NJ-1:0] wagu_on_j, acc_out_sel;
  logic [BA-1:0] obaseaddr;
  logic [BC-1:0] ocount;
  logic          shacc_load, shacc_acc, shacc_sh, shacc_imsb, shacc_wmsb;
  logic          out_valid, done;
  logic [BA-1:0] out_addr;

  always #5 clk = ~clk;

  shacc_ctrl #(.BPREC(6), .NJUMPS(NJ), .BOBANKA(BA), .BOCNT(BC), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .imsb(imsb), .wmsb(wmsb), .sh(sh),
    .wagu_on_j(wagu_on_j), .acc_out_sel(acc_out_sel), .obaseaddr(obaseaddr),
    .ocount(ocount), .shacc_load(shacc_load), .shacc_acc(shacc_acc),
    .shacc_sh(shacc_sh), .shacc_imsb(shacc_imsb), .shacc_wmsb(shacc_wmsb),
    .out_valid(out_valid), .out_addr(out_addr), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted beat is stamped with its issue cycle and
  // becomes visible exactly LAT cycles later unless a clear/reset drops it.
  typedef struct {
    int cyc;
    bit ld, eoa, sh, imsb, wmsb;
  } mbeat_t;

  mbeat_t      inflight[$];
  int          cyc = 0;
  bit          m_fp = 1'b1;
  int unsigned m_cnt = 0;
  bit          m_done = 1'b0;
  int          ov_log[$];
  int          addr_log[$];
  int          log_base = 0;

  task automatic model_reset();
    inflight.delete();
    m_fp   = 1'b1;
    m_cnt  = 0;
    m_done = 1'b0;
  endtask

  task automatic step(input bit c, input bit e, input bit s, input bit im, input bit wm,
                      input logic [NJ-1:0] j);
    mbeat_t        b, cur;
    bit            have, ev;
    logic [BA-1:0] ea;
    clr = c; en = e; sh = s; imsb = im; wmsb = wm; wagu_on_j = j;
    @(negedge clk);
    have = 1'b0;
    cur  = '{cyc: 0, ld: 0, eoa: 0, sh: 0, imsb: 0, wmsb: 0};
    if (inflight.size() > 0 && inflight[0].cyc == cyc - LAT) begin
      cur  = inflight.pop_front();
      have = 1'b1;
    end
    ev = have && cur.eoa && !m_done;
    ea = BA'(int'(obaseaddr) + m_cnt);
    check("load",  32'(shacc_load), 32'(have && cur.ld));
    check("acc",   32'(shacc_acc),  32'(have && !cur.ld));
    check("sh",    32'(shacc_sh),   32'(have && cur.sh && !cur.ld));
    check("imsb",  32'(shacc_imsb), 32'(have && cur.imsb));
    check("wmsb",  32'(shacc_wmsb), 32'(have && cur.wmsb));
    check("valid", 32'(out_valid),  32'(ev));
    check("addr",  32'(out_addr),   32'(ea));
    check("done",  32'(done),       32'(m_done));
    if (out_valid === 1'b1) begin
      ov_log.push_back(cyc - log_base);
      addr_log.push_back(int'(out_addr));
    end
    if (ev) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (ocount != 0 && m_cnt == ocount) m_done = 1'b1;
    end
    if (c) begin
      model_reset();
    end else if (e) begin
      b.cyc  = cyc;
      b.ld   = m_fp;
      b.eoa  = |(j & acc_out_sel);
      b.sh   = s;
      b.imsb = im;
      b.wmsb = wm;
      inflight.push_back(b);
      m_fp = b.eoa;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NJ-1:0] jj;
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; sh = 1'b0; imsb = 1'b0; wmsb = 1'b0;
    wagu_on_j = '0; acc_out_sel = 5'b00010; obaseaddr = 15'h100; ocount = 16'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  32'(out_addr), 32'h100);
    check("rst_ctl",   32'({shacc_load, shacc_acc, shacc_sh, shacc_imsb, shacc_wmsb}), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two accumulations of four beats each, ocount=2
    step(1, 0, 0, 0, 0, '0);
    log_base = cyc;
    ov_log.delete();
    addr_log.delete();
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, (i == 3 || i == 7) ? 5'b00010 : 5'b00000);
    idle(4);
    check("plan_nvalid", 32'(ov_log.size()), 32'd2);
    if (ov_log.size() == 2) begin
      check("plan_cyc0",  32'(ov_log[0]),   32'd6);
      check("plan_cyc1",  32'(ov_log[1]),   32'd10);
      check("plan_addr0", 32'(addr_log[0]), 32'h100);
      check("plan_addr1", 32'(addr_log[1]), 32'h101);
    end
    check("plan_done", 32'(done), 32'd1);

    // Bubbles inside one accumulation
    ocount = 16'd0;
    step(1, 0, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, 5'b00000);
    step(0, 0, 0, 0, 0, 5'b00000);
    step(0, 1, 0, 0, 0, 5'b00000);
    step(0, 1, 0, 0, 0, 5'b00010);
    idle(4);

    // Single-beat accumulations, unlimited count
    acc_out_sel = 5'b00001;
    step(1, 0, 0, 0, 0, '0);
    ov_log.delete();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 5'b00001);
    idle(4);
    check("single_nvalid", 32'(ov_log.size()), 32'd5);
    check("single_done",   32'(done), 32'd0);

    // Shift/sign flags, including sh on a load beat
    step(1, 0, 0, 0, 0, '0);
    step(0, 1, 1, 0, 1, 5'b00000);
    step(0, 1, 1, 1, 0, 5'b00000);
    step(0, 1, 0, 1, 1, 5'b00001);
    idle(4);

    // clr with beats in flight, then restart
    obaseaddr = 15'h200;
    step(1, 0, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, 5'b00001);
    step(0, 1, 0, 0, 0, 5'b00001);
    step(1, 1, 1, 1, 1, 5'b00001);
    step(0, 1, 0, 0, 0, 5'b00001);
    idle(4);
    check("clr_restart_addr", 32'(out_addr), 32'h201);

    // Random traffic, reconfigured only on clr
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        acc_out_sel = NJ'($urandom());
        obaseaddr   = ($urandom_range(0, 1) == 0) ? BA'(15'h7FFC) : BA'($urandom());
        ocount      = BC'($urandom_range(0, 8));
        step(1, 1'($urandom()), 0, 0, 0, NJ'($urandom()));
      end else begin
        jj = ($urandom_range(0, 3) == 0) ? NJ'($urandom()) : '0;
        step(0, $urandom_range(0, 3) != 0, 1'($urandom()), 1'($urandom()), 1'($urandom()), jj);
      end
    end

    // Asynchronous reset with a full pipeline
    acc_out_sel = 5'b00001; obaseaddr = 15'h0AB; ocount = 16'd0;
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 1, (i == 1) ? 5'b00001 : 5'b00000);
    check("pre_rst_busy", 32'(shacc_load | shacc_acc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctl",   32'({shacc_load, shacc_acc, shacc_sh, shacc_imsb, shacc_wmsb}), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_addr",  32'(out_addr), 32'h0AB);
    check("arst_done",  32'(done), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_addr", 32'(out_addr), 32'h0AB);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, (i == 2) ? 5'b00001 : 5'b00000);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
